cim_mem_arb: RTL and testbench
==============================

Name: cim_mem_arb

Overview:
- Parametrised successor to the CIM single-port memory front-end.
- One single-port storage array shared by N_REQ requesters (BUS_FSM, LOGIC_FSM, MAC, LAYERNORM, DATA_FILL_FSM, DENSE_BROADCAST_SAVE_FSM, ...).
- Adds real arbitration with request/grant handshake, ID-tagged read return with configurable latency, selectable fixed-priority or round-robin mode, per-requester write permission, and conflict/illegal-access status.
- One instance each is used for the intermediate-results memory and the params memory.

Parameters:
- DATA_W, 16: word width in bits.
- DEPTH, 528: number of words; ADDR_W = $clog2(DEPTH).
- N_REQ, 6: number of requesters; index 0 is highest fixed priority.
- RD_LAT, 1: read latency in cycles, from grant edge to rvalid; legal values 1 or 2.
- ARB_MODE, 0: 0 = fixed priority, 1 = round-robin.
- WR_EN_MASK, 6'b111011: bit i = 1 means requester i may write; MAC (bit 2) is read-only.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester access request; held until granted.
- wen  in  N_REQ  per-requester: 1 = write, 0 = read; qualified by req.
- addr  in  N_REQ*ADDR_W  packed addresses; requester i at slice [i*ADDR_W +: ADDR_W].
- wdata  in  N_REQ*DATA_W  packed write data, same slicing.
- gnt  out  N_REQ  one-hot or zero grant, combinational in the request cycle.
- rvalid  out  1  read data valid.
- rvalid_id  out  $clog2(N_REQ)  requester index owning rdata.
- rdata  out  DATA_W  read data.
- conflict_cnt  out  16  saturating count of cycles with more than one eligible request.
- err_illegal_wr  out  1  sticky; set on a write request from a requester whose WR_EN_MASK bit is 0.

Behaviour:
- Reset, asynchronous on rst_n low:
  - rvalid=0, rvalid_id=0, rdata=0, conflict_cnt=0, err_illegal_wr=0.
  - Read pipeline flushed; in-flight reads are lost, not replayed.
  - Round-robin pointer = 0.
  - Array contents are not reset.
- Eligibility: requester i is eligible when req[i] && !(wen[i] && !WR_EN_MASK[i]).
- Illegal write: an ineligible write request is never granted. It sets err_illegal_wr at the next edge; the flag is sticky until reset.
- Arbitration is combinational in cycle t and produces at most one gnt bit.
  - Fixed mode: lowest-index eligible requester wins.
  - RR mode: first eligible requester at or after ptr, wrapping N_REQ-1 -> 0.
  - RR pointer: after any grant to index g, ptr <= (g+1) mod N_REQ, wrapping at N_REQ-1. No grant leaves ptr unchanged.
- Handshake: a requester that sees gnt[i]=1 in cycle t is served at edge t and may change or drop req in cycle t+1. A loser must hold req, wen, addr and wdata stable.
- Write: array[addr_g] <= wdata_g at the grant edge. No read response is produced.
- Read: the array is sampled at the grant edge.
  - RD_LAT=1: rvalid=1, rdata, rvalid_id=g during cycle t+1.
  - RD_LAT=2: the same response during cycle t+2, through an extra output register stage.
  - Back-to-back reads are fully pipelined: one grant per cycle, responses in order.
- Read-after-write to the same address in consecutive grants returns the new data. Write and read to the same address in the same cycle is impossible because only one grant is issued per cycle.
- rdata holds its last value when rvalid=0.
- conflict_cnt increments on every cycle with at least 2 eligible requesters and saturates at 16'hFFFF.
- An address >= DEPTH is a simulation assertion error. In RTL the write is dropped and a read returns 0.
- Simulation assertions: gnt is $onehot0; a granted write index has WR_EN_MASK set.

Decomposition:
- Shared package cim_mem_pkg:
  - MemReqSrc_t enum of requester indices.
  - ArbMode_t enum {ARB_FIXED, ARB_RR}.
  - Default WR_EN_MASK constants for the int_res and params instances.
  - DEPTH constants for both memories.
- Sub-module cim_rr_arbiter: N_REQ-wide eligibility-to-one-hot grant with a mode input and pointer register.
- Array, read pipeline and status counters stay in cim_mem_arb.

Test Plan:
- Fixed mode: write 0x1234 @5 from req0, then a read @5 from req3 -> gnt=6'b001000 in the read cycle; rvalid=1, rvalid_id=3, rdata=0x1234 exactly RD_LAT cycles later.
- Fixed mode, req0, req1 and req3 all reading and held -> grants in order 0, 1, 3 on consecutive cycles; conflict_cnt=2; responses in order.
- RR mode, all 6 reading continuously for 12 cycles -> grant sequence 0,1,2,3,4,5,0,...; each requester gets exactly 2 grants.
- req2 (MAC) write @7 with data 0xBEEF -> never granted; err_illegal_wr=1 next cycle and stays 1; a later read @7 returns the previous value.
- RD_LAT=2, reads @1, @2, @3 granted back-to-back -> rvalid high for 3 consecutive cycles starting t+2, with the correct data and IDs.
- Drop rst_n mid-stream with a read in flight -> rvalid falls to 0 immediately; no response after reset release; RR ptr = 0 (first grant goes to the lowest eligible index).

Source files
------------

// File: rtl/cim_mem_pkg.sv
// Shared definitions for the CIM single-port memory arbiters.
package cim_mem_pkg;

  typedef enum logic [2:0] {
    SRC_BUS         = 3'd0,
    SRC_LOGIC       = 3'd1,
    SRC_MAC         = 3'd2,
    SRC_LAYERNORM   = 3'd3,
    SRC_DATA_FILL   = 3'd4,
    SRC_DENSE_BCAST = 3'd5
  } MemReqSrc_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } ArbMode_t;

  // MAC only ever reads the intermediate-results memory.
  localparam logic [5:0] INT_RES_WR_EN_MASK = 6'b111011;
  // Params memory is loaded only by the bus and the data-fill engine.
  localparam logic [5:0] PARAMS_WR_EN_MASK  = 6'b010001;

  localparam int unsigned INT_RES_DEPTH = 528;
  localparam int unsigned PARAMS_DEPTH  = 1024;

endpackage

// File: rtl/cim_rr_arbiter.sv
// One-hot grant from an eligibility vector, fixed-priority or round-robin.
module cim_rr_arbiter
  import cim_mem_pkg::*;
#(
  parameter int unsigned N_REQ = 6,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  ArbMode_t         mode,
  input  logic [N_REQ-1:0] elig,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] base;
  logic             found;

  // Two passes over the requesters: first indices at/after base, then the
  // wrapped ones below it. Fixed mode uses base 0, so pass 0 covers all.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    base    = (mode == ARB_RR) ? ptr : '0;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found && elig[i] && ((pass == 0) == (i >= 32'(base)))) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = IDX_W'(i);
        end
      end
    end
  end

  // Pointer moves just past the last winner; idle cycles leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cim_mem_arb.sv
// Single-port memory shared by N_REQ requesters with arbitration,
// ID-tagged read return and access status.
module cim_mem_arb
  import cim_mem_pkg::*;
#(
  parameter int unsigned      DATA_W     = 16,
  parameter int unsigned      DEPTH      = INT_RES_DEPTH,
  parameter int unsigned      N_REQ      = 6,
  parameter int unsigned      RD_LAT     = 1,
  parameter int unsigned      ARB_MODE   = 0,
  parameter logic [N_REQ-1:0] WR_EN_MASK = N_REQ'(INT_RES_WR_EN_MASK),
  localparam int unsigned     ADDR_W     = $clog2(DEPTH),
  localparam int unsigned     ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        wen,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rvalid,
  output logic [ID_W-1:0]         rvalid_id,
  output logic [DATA_W-1:0]       rdata,
  output logic [15:0]             conflict_cnt,
  output logic                    err_illegal_wr
);

  localparam ArbMode_t MODE = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  illegal_wr;
  logic [ID_W-1:0]   gnt_idx;
  logic              any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_wen;
  logic              in_range;
  logic              do_wr;
  logic              do_rd;

  logic              rd1_valid;
  logic [ID_W-1:0]   rd1_id;
  logic [DATA_W-1:0] rd1_data;

  assign elig       = req & ~(wen & ~WR_EN_MASK);
  assign illegal_wr = req & wen & ~WR_EN_MASK;

  cim_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (MODE),
    .elig   (elig),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  // Route the granted requester's command onto the array port.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wen   = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
        sel_wen   = wen[i];
      end
    end
  end

  assign any_gnt  = |gnt;
  assign in_range = (32'(sel_addr) < DEPTH);
  assign do_wr    = any_gnt & sel_wen & in_range;
  assign do_rd    = any_gnt & ~sel_wen;

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  // First read stage: array sampled at the grant edge; data/ID hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_valid <= 1'b0;
      rd1_id    <= '0;
      rd1_data  <= '0;
    end else begin
      rd1_valid <= do_rd;
      if (do_rd) begin
        rd1_id   <= gnt_idx;
        rd1_data <= in_range ? mem[sel_addr] : '0;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              rd2_valid;
      logic [ID_W-1:0]   rd2_id;
      logic [DATA_W-1:0] rd2_data;

      // Extra output register stage for the two-cycle latency build.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd2_valid <= 1'b0;
          rd2_id    <= '0;
          rd2_data  <= '0;
        end else begin
          rd2_valid <= rd1_valid;
          if (rd1_valid) begin
            rd2_id   <= rd1_id;
            rd2_data <= rd1_data;
          end
        end
      end

      assign rvalid    = rd2_valid;
      assign rvalid_id = rd2_id;
      assign rdata     = rd2_data;
    end else begin : g_lat1
      assign rvalid    = rd1_valid;
      assign rvalid_id = rd1_id;
      assign rdata     = rd1_data;
    end
  endgenerate

  // Saturating contention counter and sticky illegal-write flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt   <= '0;
      err_illegal_wr <= 1'b0;
    end else begin
      if (($countones(elig) >= 2) && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
      if (|illegal_wr) begin
        err_illegal_wr <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // Protocol checks on the arbitration result.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(gnt))
        else $error("cim_mem_arb: grant not one-hot: %b", gnt);
      assert ((gnt & wen & ~WR_EN_MASK) == '0)
        else $error("cim_mem_arb: write granted to read-only requester: %b", gnt);
      assert (!any_gnt || in_range)
        else $error("cim_mem_arb: address %0d beyond DEPTH", sel_addr);
    end
  end
`endif

endmodule

// File: tb/tb_cim_mem_arb.sv
// Directed self-checking bench: fixed/RD_LAT=1, RR/RD_LAT=1 and
// fixed/RD_LAT=2 instances share one stimulus stream.
module tb_cim_mem_arb;

  localparam int unsigned N  = 6;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  wen;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;

  logic [N-1:0]  g0, g1, g2;
  logic          rv0, rv1, rv2;
  logic [2:0]    rid0, rid1, rid2;
  logic [DW-1:0] rd0, rd1, rd2;
  logic [15:0]   cc0, cc1, cc2;
  logic          err0, err1, err2;

  int checks = 0;
  int errors = 0;
  int gcount [N];

  always #5 clk = ~clk;

  cim_mem_arb #(.DATA_W(16), .DEPTH(528), .N_REQ(6), .RD_LAT(1), .ARB_MODE(0),
                .WR_EN_MASK(6'b111011)) dut_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
    .gnt(g0), .rvalid(rv0), .rvalid_id(rid0), .rdata(rd0),
    .conflict_cnt(cc0), .err_illegal_wr(err0));

  cim_mem_arb #(.DATA_W(16), .DEPTH(528), .N_REQ(6), .RD_LAT(1), .ARB_MODE(1),
                .WR_EN_MASK(6'b111011)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
    .gnt(g1), .rvalid(rv1), .rvalid_id(rid1), .rdata(rd1),
    .conflict_cnt(cc1), .err_illegal_wr(err1));

  cim_mem_arb #(.DATA_W(16), .DEPTH(528), .N_REQ(6), .RD_LAT(2), .ARB_MODE(0),
                .WR_EN_MASK(6'b111011)) dut_lat2 (
    .clk(clk), .rst_n(rst_n), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
    .gnt(g2), .rvalid(rv2), .rvalid_id(rid2), .rdata(rd2),
    .conflict_cnt(cc2), .err_illegal_wr(err2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic put(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]              = 1'b1;
    wen[i]              = w;
    addr[i*AW +: AW]    = a;
    wdata[i*DW +: DW]   = d;
  endtask

  task automatic idle();
    req = '0;
    wen = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    wen   = '0;
    addr  = '0;
    wdata = '0;
    step();
    step();
    chk("rst_rvalid",   rv0,  0);
    chk("rst_rvalid_id", rid0, 0);
    chk("rst_rdata",    rd0,  0);
    chk("rst_conflict", cc0,  0);
    chk("rst_err",      err0, 0);
    chk("rst_rvalid_l2", rv2, 0);
    rst_n = 1'b1;
    step();

    // Round-robin: all six read continuously for 12 cycles
    for (int i = 0; i < 6; i++) put(i, 1'b0, AW'(i), '0);
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("rr_gnt", g1, 32'(6'b000001 << (k % 6)));
      for (int j = 0; j < 6; j++) if (g1[j]) gcount[j]++;
      step();
      chk("rr_rvalid", rv1, 1);
      chk("rr_rid", rid1, 32'(k % 6));
    end
    idle();
    for (int j = 0; j < 6; j++) chk("rr_count", gcount[j], 2);
    chk("rr_conflict", cc1, 12);
    chk("fix_conflict_after_rr", cc0, 12);
    step();

    // Fixed: write 0x1234 @5 from req0, then read @5 from req3
    put(0, 1'b1, 10'd5, 16'h1234);
    #1;
    chk("wr_gnt", g0, 6'b000001);
    step();
    chk("wr_no_rvalid", rv0, 0);
    idle();
    put(3, 1'b0, 10'd5, '0);
    #1;
    chk("rd_gnt", g0, 6'b001000);
    step();
    chk("rd_rvalid", rv0, 1);
    chk("rd_rid", rid0, 3);
    chk("rd_rdata", rd0, 16'h1234);
    chk("l2_not_yet", rv2, 0);
    idle();
    step();
    chk("rd_rvalid_drop", rv0, 0);
    chk("rd_rdata_hold", rd0, 16'h1234);
    chk("l2_rvalid", rv2, 1);
    chk("l2_rid", rid2, 3);
    chk("l2_rdata", rd2, 16'h1234);

    // Fixed: preload, then req0/1/3 reading and held until granted
    put(0, 1'b1, 10'd10, 16'hA0A0); step(); idle();
    put(1, 1'b1, 10'd11, 16'hB1B1); step(); idle();
    put(4, 1'b1, 10'd13, 16'hD3D3); step(); idle();
    chk("pre_conflict", cc0, 12);
    put(0, 1'b0, 10'd10, '0);
    put(1, 1'b0, 10'd11, '0);
    put(3, 1'b0, 10'd13, '0);
    #1;
    chk("multi_gnt0", g0, 6'b000001);
    step();
    chk("multi_cc1", cc0, 13);
    chk("multi_rid0", rid0, 0);
    chk("multi_rd0", rd0, 16'hA0A0);
    req[0] = 1'b0;
    #1;
    chk("multi_gnt1", g0, 6'b000010);
    step();
    chk("multi_cc2", cc0, 14);
    chk("multi_rid1", rid0, 1);
    chk("multi_rd1", rd0, 16'hB1B1);
    req[1] = 1'b0;
    #1;
    chk("multi_gnt3", g0, 6'b001000);
    step();
    chk("multi_cc3", cc0, 14);
    chk("multi_rv3", rv0, 1);
    chk("multi_rid3", rid0, 3);
    chk("multi_rd3", rd0, 16'hD3D3);
    idle();

    // Illegal write from MAC
    put(0, 1'b1, 10'd7, 16'h7777); step(); idle();
    put(2, 1'b1, 10'd7, 16'hBEEF);
    #1;
    chk("ill_gnt", g0, 0);
    chk("ill_err_before", err0, 0);
    step();
    chk("ill_err_set", err0, 1);
    chk("ill_gnt_held", g0, 0);
    idle();
    step();
    chk("ill_err_sticky", err0, 1);
    put(2, 1'b0, 10'd7, '0);
    #1;
    chk("mac_rd_gnt", g0, 6'b000100);
    step();
    chk("mac_rd_rid", rid0, 2);
    chk("mac_rd_data", rd0, 16'h7777);
    idle();
    step();
    chk("ill_err_still", err0, 1);

    // RD_LAT=2 back-to-back reads @1,@2,@3
    put(0, 1'b1, 10'd1, 16'h0101); step(); idle();
    put(0, 1'b1, 10'd2, 16'h0202); step(); idle();
    put(0, 1'b1, 10'd3, 16'h0303); step(); idle();
    put(1, 1'b0, 10'd1, '0);
    #1;
    chk("l2_gnt_a", g2, 6'b000010);
    step();
    chk("l2_idle_a", rv2, 0);
    idle();
    put(3, 1'b0, 10'd2, '0);
    #1;
    chk("l2_gnt_b", g2, 6'b001000);
    step();
    chk("l2_rv_a", rv2, 1);
    chk("l2_id_a", rid2, 1);
    chk("l2_d_a", rd2, 16'h0101);
    idle();
    put(5, 1'b0, 10'd3, '0);
    #1;
    chk("l2_gnt_c", g2, 6'b100000);
    step();
    chk("l2_rv_b", rv2, 1);
    chk("l2_id_b", rid2, 3);
    chk("l2_d_b", rd2, 16'h0202);
    idle();
    step();
    chk("l2_rv_c", rv2, 1);
    chk("l2_id_c", rid2, 5);
    chk("l2_d_c", rd2, 16'h0303);
    step();
    chk("l2_rv_end", rv2, 0);
    chk("l2_d_hold", rd2, 16'h0303);

    // Reset with a read in flight
    put(4, 1'b0, 10'd1, '0);
    step();
    idle();
    chk("flight_rv", rv0, 1);
    chk("flight_rd", rd0, 16'h0101);
    rst_n = 1'b0;
    #1;
    chk("arst_rv", rv0, 0);
    chk("arst_rd", rd0, 0);
    chk("arst_rv_l2", rv2, 0);
    chk("arst_err", err0, 0);
    chk("arst_cc", cc0, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rv", rv0, 0);
    chk("post_rv_l2", rv2, 0);
    step();
    chk("post_rv_l2b", rv2, 0);
    put(1, 1'b0, 10'd2, '0);
    put(5, 1'b0, 10'd3, '0);
    #1;
    chk("post_rr_gnt", g1, 6'b000010);
    chk("post_fix_gnt", g0, 6'b000010);
    step();
    chk("post_rr_rid", rid1, 1);
    chk("post_rr_rd", rd1, 16'h0202);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
